result_packer: RTL and testbench

Write-side counterpart of the matrix input FIFO in the ternary matmul unit. Accepts result elements one per cycle from the accumulator datapath and packs them, lane 0 first, into full-width DDR words. Completed words are buffered in a small FIFO and presented to the DDR write port with a valid/ready handshake. A `last_i` marker closes a partial word, which is zero-padded and carries a byte-enable mask.

---
 rtl/result_packer.sv | 99 +++++++++
 tb/tb_result_packer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/result_packer.sv
// Packs result elements lane 0 first into DDR-width words and buffers the
// completed words in a small FIFO behind a valid/ready write port.
module result_packer #(
    parameter int unsigned ElemWidth     = 32,
    parameter int unsigned DdrDataWidth  = 512,
    parameter int unsigned WordFifoDepth = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [ElemWidth-1:0]      elem_i,
    input  logic                      elem_valid_i,
    input  logic                      elem_last_i,
    output logic                      elem_ready_o,
    output logic [DdrDataWidth-1:0]   ddr_data_o,
    output logic [DdrDataWidth/8-1:0] ddr_be_o,
    output logic                      ddr_valid_o,
    input  logic                      ddr_ready_i,
    output logic                      busy_o
);

    localparam int unsigned LanesPerWord = DdrDataWidth / ElemWidth;
    localparam int unsigned BytesPerLane = ElemWidth / 8;
    localparam int unsigned BeWidth      = DdrDataWidth / 8;
    localparam int unsigned LaneIdxW     = (LanesPerWord > 1) ? $clog2(LanesPerWord) : 1;
    localparam int unsigned PtrW         = $clog2(WordFifoDepth);
    localparam int unsigned CntW         = $clog2(WordFifoDepth + 1);

    localparam logic [LaneIdxW-1:0] LastLane = LaneIdxW'(LanesPerWord - 1);
    localparam logic [CntW-1:0]     FullCnt  = CntW'(WordFifoDepth);

    logic [DdrDataWidth-1:0] asm_data_q, asm_data_next;
    logic [BeWidth-1:0]      asm_be_q, asm_be_next;
    logic [LaneIdxW-1:0]     lane_q;

    logic [DdrDataWidth-1:0] mem_data [WordFifoDepth];
    logic [BeWidth-1:0]      mem_be   [WordFifoDepth];
    logic [PtrW-1:0]         head_q, tail_q;
    logic [CntW-1:0]         cnt_q;

    logic accept, commit, pop;

    assign elem_ready_o = (cnt_q != FullCnt);
    assign ddr_valid_o  = (cnt_q != '0);
    assign accept       = elem_valid_i && elem_ready_o;
    assign commit       = accept && ((lane_q == LastLane) || elem_last_i);
    assign pop          = ddr_valid_o && ddr_ready_i;
    assign busy_o       = (lane_q != '0) || (cnt_q != '0);

    assign ddr_data_o = ddr_valid_o ? mem_data[head_q] : '0;
    assign ddr_be_o   = ddr_valid_o ? mem_be[head_q]   : '0;

    // The word pushed on a commit includes the element accepted on that edge.
    always_comb begin
        asm_data_next = asm_data_q;
        asm_be_next   = asm_be_q;
        asm_data_next[lane_q*ElemWidth +: ElemWidth]      = elem_i;
        asm_be_next[lane_q*BytesPerLane +: BytesPerLane]  = '1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            asm_data_q <= '0;
            asm_be_q   <= '0;
            lane_q     <= '0;
        end else if (commit) begin
            asm_data_q <= '0;
            asm_be_q   <= '0;
            lane_q     <= '0;
        end else if (accept) begin
            asm_data_q <= asm_data_next;
            asm_be_q   <= asm_be_next;
            lane_q     <= lane_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (commit && !rst_i) begin
            mem_data[tail_q] <= asm_data_next;
            mem_be[tail_q]   <= asm_be_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (commit) tail_q <= tail_q + 1'b1;
            if (pop)    head_q <= head_q + 1'b1;
            case ({commit, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: tb/tb_result_packer.sv
// Scoreboard bench for result_packer: 4 lanes of 32 bits, 2-word FIFO.
module tb_result_packer;

    localparam int unsigned EW = 32;
    localparam int unsigned DW = 128;
    localparam int unsigned BW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic [EW-1:0] elem_i = '0;
    logic          elem_valid_i = 1'b0;
    logic          elem_last_i = 1'b0;
    logic          elem_ready_o;
    logic [DW-1:0] ddr_data_o;
    logic [BW-1:0] ddr_be_o;
    logic          ddr_valid_o;
    logic          ddr_ready_i = 1'b1;
    logic          busy_o;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    logic [DW-1:0] exp_data_q [$];
    logic [BW-1:0] exp_be_q   [$];

    logic          stall_seen = 1'b0;
    logic [DW-1:0] stall_data;
    logic [BW-1:0] stall_be;

    result_packer #(
        .ElemWidth    (EW),
        .DdrDataWidth (DW),
        .WordFifoDepth(2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .elem_i      (elem_i),
        .elem_valid_i(elem_valid_i),
        .elem_last_i (elem_last_i),
        .elem_ready_o(elem_ready_o),
        .ddr_data_o  (ddr_data_o),
        .ddr_be_o    (ddr_be_o),
        .ddr_valid_o (ddr_valid_o),
        .ddr_ready_i (ddr_ready_i),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic expect_word(input logic [DW-1:0] d, input logic [BW-1:0] be);
        exp_data_q.push_back(d);
        exp_be_q.push_back(be);
    endtask

    // Presents one element from just after a rising edge and returns just
    // after the edge that accepted it.
    task automatic send(input logic [EW-1:0] e, input logic l);
        int unsigned waited = 0;
        elem_i       = e;
        elem_last_i  = l;
        elem_valid_i = 1'b1;
        forever begin
            @(negedge clk);
            if (elem_ready_o) break;
            waited++;
            if (waited > 200) begin
                chk("ready_timeout", 1'b0, 1'b1);
                break;
            end
        end
        @(posedge clk);
        #1;
        elem_valid_i = 1'b0;
        elem_last_i  = 1'b0;
    endtask

    task automatic wait_drain();
        int unsigned n = 0;
        while ((exp_data_q.size() != 0 || busy_o) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_busy", busy_o, 1'b0);
        chk("drain_queue", exp_data_q.size(), 0);
    endtask

    // Monitor: handshake completes at the next edge when valid && ready now.
    always @(negedge clk) begin
        if (!rst_i && ddr_valid_o && stall_seen) begin
            chk("stall_data", ddr_data_o, stall_data);
            chk("stall_be", ddr_be_o, stall_be);
        end
        stall_seen = !rst_i && ddr_valid_o && !ddr_ready_i;
        stall_data = ddr_data_o;
        stall_be   = ddr_be_o;
        if (!rst_i && ddr_valid_o && ddr_ready_i) begin
            if (exp_data_q.size() == 0) begin
                chk("unexpected_word", ddr_data_o, '0);
            end else begin
                chk("word_data", ddr_data_o, exp_data_q.pop_front());
                chk("word_be", ddr_be_o, exp_be_q.pop_front());
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst_valid", ddr_valid_o, 1'b0);
        chk("rst_data", ddr_data_o, '0);
        chk("rst_be", ddr_be_o, '0);
        chk("rst_ready", elem_ready_o, 1'b1);
        chk("rst_busy", busy_o, 1'b0);
        @(posedge clk);
        #1;

        // Full word, one-cycle latency
        expect_word(128'h00000004_00000003_00000002_00000001, 16'hFFFF);
        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        send(32'd3, 1'b0);
        chk("full_valid_early", ddr_valid_o, 1'b0);
        send(32'd4, 1'b0);
        chk("full_valid_latency", ddr_valid_o, 1'b1);
        wait_drain();

        // Partial word, then single element lands in lane 0
        expect_word(128'h00000000_00000000_0000000B_0000000A, 16'h00FF);
        send(32'hA, 1'b0);
        send(32'hB, 1'b1);
        expect_word(128'h00000000_00000000_00000000_00000055, 16'h000F);
        send(32'h55, 1'b1);
        wait_drain();

        // Backpressure
        ddr_ready_i = 1'b0;
        expect_word(128'h00000004_00000003_00000002_00000001, 16'hFFFF);
        expect_word(128'h00000008_00000007_00000006_00000005, 16'hFFFF);
        expect_word(128'h0000000C_0000000B_0000000A_00000009, 16'hFFFF);
        for (int i = 1; i <= 7; i++) send(EW'(i), 1'b0);
        chk("bp_ready_after7", elem_ready_o, 1'b1);
        send(32'd8, 1'b0);
        chk("bp_ready_after8", elem_ready_o, 1'b0);
        chk("bp_busy", busy_o, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_ready_held", elem_ready_o, 1'b0);
        ddr_ready_i = 1'b1;
        @(negedge clk);
        chk("bp_no_passthru", elem_ready_o, 1'b0);
        @(posedge clk);
        #1;
        chk("bp_ready_back", elem_ready_o, 1'b1);
        for (int i = 9; i <= 12; i++) send(EW'(i), 1'b0);
        wait_drain();

        // Continuous stream with toggling ddr_ready_i
        expect_word(128'h00000013_00000012_00000011_00000010, 16'hFFFF);
        expect_word(128'h00000017_00000016_00000015_00000014, 16'hFFFF);
        fork
            begin
                for (int i = 16; i < 24; i++) send(EW'(i), 1'b0);
            end
            begin
                for (int k = 0; k < 16; k++) begin
                    @(posedge clk);
                    #1;
                    ddr_ready_i = ~ddr_ready_i;
                end
            end
        join
        ddr_ready_i = 1'b1;
        wait_drain();

        // Reset mid-word
        send(32'hEE01, 1'b0);
        send(32'hEE02, 1'b0);
        send(32'hEE03, 1'b0);
        chk("pre_rst_busy", busy_o, 1'b1);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        chk("post_rst_busy", busy_o, 1'b0);
        chk("post_rst_valid", ddr_valid_o, 1'b0);
        chk("post_rst_ready", elem_ready_o, 1'b1);
        expect_word(128'h00000024_00000023_00000022_00000021, 16'hFFFF);
        for (int i = 33; i <= 36; i++) send(EW'(i), 1'b0);
        wait_drain();

        repeat (5) @(posedge clk);
        #1;
        chk("final_valid", ddr_valid_o, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
